// File: rtl/superh16_branch_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : superh16_branch_redirect_ctrl_if
// Description : Branch-resolution inputs and redirect/flush/statistics outputs
//               of the branch redirect controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface superh16_branch_redirect_ctrl_if #(
    parameter int NUM_BR       = 2,
    parameter int VADDR_WIDTH  = 64,
    parameter int ROB_IDX_BITS = 8
);
    logic [NUM_BR-1:0]              br_resolved;
    logic [NUM_BR-1:0]              br_mispredicted;
    logic [NUM_BR*VADDR_WIDTH-1:0]  br_target;
    logic [NUM_BR*ROB_IDX_BITS-1:0] br_rob_idx;
    logic [ROB_IDX_BITS-1:0]        rob_head;
    logic                           exc_flush;
    logic                           redirect_ready;
    logic                           redirect_valid;
    logic [VADDR_WIDTH-1:0]         redirect_pc;
    logic                           flush_valid;
    logic [ROB_IDX_BITS-1:0]        flush_rob_idx;
    logic [31:0]                    stat_resolved;
    logic [31:0]                    stat_mispred;

    modport master (
        output br_resolved, br_mispredicted, br_target, br_rob_idx,
               rob_head, exc_flush, redirect_ready,
        input  redirect_valid, redirect_pc, flush_valid, flush_rob_idx,
               stat_resolved, stat_mispred
    );

    modport slave (
        input  br_resolved, br_mispredicted, br_target, br_rob_idx,
               rob_head, exc_flush, redirect_ready,
        output redirect_valid, redirect_pc, flush_valid, flush_rob_idx,
               stat_resolved, stat_mispred
    );
endinterface
`default_nettype wire

// File: rtl/superh16_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : superh16_branch_redirect_ctrl
// Description : Picks the oldest mispredicted branch, pulses a ROB flush and
//               holds a fetch redirect until accepted; keeps saturating stats.
// Revision    : 1.0 - initial release
// ============================================================================
module superh16_branch_redirect_ctrl #(
    parameter int NUM_BR       = 2,
    parameter int VADDR_WIDTH  = 64,
    parameter int ROB_IDX_BITS = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    superh16_branch_redirect_ctrl_if.slave  bus
);
    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    localparam logic [31:0] c_STAT_MAX = 32'hFFFF_FFFF;

    state_t                  r_state_q,          w_state_d;
    logic                    r_redirect_valid_q, w_redirect_valid_d;
    logic [VADDR_WIDTH-1:0]  r_redirect_pc_q,    w_redirect_pc_d;
    logic                    r_flush_valid_q,    w_flush_valid_d;
    logic [ROB_IDX_BITS-1:0] r_flush_rob_idx_q,  w_flush_rob_idx_d;
    logic [31:0]             r_stat_resolved_q,  w_stat_resolved_d;
    logic [31:0]             r_stat_mispred_q,   w_stat_mispred_d;

    logic                    w_pick_found;
    logic [ROB_IDX_BITS-1:0] w_pick_age;
    logic [ROB_IDX_BITS-1:0] w_pick_rob_idx;
    logic [VADDR_WIDTH-1:0]  w_pick_target;
    logic [ROB_IDX_BITS-1:0] w_latched_age;
    logic                    w_accept;
    logic [32:0]             w_resolved_sum;

    // Oldest candidate by modular distance from the ROB head; strict compare keeps the lower lane on ties.
    always_comb begin
        logic [ROB_IDX_BITS-1:0] w_lane_age;
        w_pick_found   = 1'b0;
        w_pick_age     = '0;
        w_pick_rob_idx = '0;
        w_pick_target  = '0;
        w_lane_age     = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            w_lane_age = bus.br_rob_idx[i*ROB_IDX_BITS +: ROB_IDX_BITS] - bus.rob_head;
            if (bus.br_resolved[i] && bus.br_mispredicted[i] &&
                (!w_pick_found || (w_lane_age < w_pick_age))) begin
                w_pick_found   = 1'b1;
                w_pick_age     = w_lane_age;
                w_pick_rob_idx = bus.br_rob_idx[i*ROB_IDX_BITS +: ROB_IDX_BITS];
                w_pick_target  = bus.br_target[i*VADDR_WIDTH +: VADDR_WIDTH];
            end
        end
    end

    assign w_latched_age = r_flush_rob_idx_q - bus.rob_head;

    always_comb begin
        w_state_d          = r_state_q;
        w_redirect_valid_d = r_redirect_valid_q;
        w_redirect_pc_d    = r_redirect_pc_q;
        w_flush_valid_d    = 1'b0;
        w_flush_rob_idx_d  = r_flush_rob_idx_q;
        w_accept           = 1'b0;

        if (bus.exc_flush) begin
            w_state_d          = ST_IDLE;
            w_redirect_valid_d = 1'b0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    w_accept = w_pick_found;
                end
                ST_REDIRECT: begin
                    // An older pick overrides even a handshake in the same cycle.
                    if (w_pick_found && (w_pick_age < w_latched_age)) begin
                        w_accept = 1'b1;
                    end else if (r_redirect_valid_q && bus.redirect_ready) begin
                        w_state_d          = ST_IDLE;
                        w_redirect_valid_d = 1'b0;
                    end
                end
                default: begin
                    w_state_d          = ST_IDLE;
                    w_redirect_valid_d = 1'b0;
                end
            endcase

            if (w_accept) begin
                w_state_d          = ST_REDIRECT;
                w_redirect_valid_d = 1'b1;
                w_redirect_pc_d    = w_pick_target;
                w_flush_valid_d    = 1'b1;
                w_flush_rob_idx_d  = w_pick_rob_idx;
            end
        end
    end

    always_comb begin
        w_resolved_sum = {1'b0, r_stat_resolved_q};
        for (int i = 0; i < NUM_BR; i++) begin
            w_resolved_sum = w_resolved_sum + {32'd0, bus.br_resolved[i]};
        end
        w_stat_resolved_d = w_resolved_sum[32] ? c_STAT_MAX : w_resolved_sum[31:0];

        w_stat_mispred_d = r_stat_mispred_q;
        if (w_accept && (r_stat_mispred_q != c_STAT_MAX)) begin
            w_stat_mispred_d = r_stat_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q          <= ST_IDLE;
            r_redirect_valid_q <= 1'b0;
            r_redirect_pc_q    <= '0;
            r_flush_valid_q    <= 1'b0;
            r_flush_rob_idx_q  <= '0;
            r_stat_resolved_q  <= '0;
            r_stat_mispred_q   <= '0;
        end else begin
            r_state_q          <= w_state_d;
            r_redirect_valid_q <= w_redirect_valid_d;
            r_redirect_pc_q    <= w_redirect_pc_d;
            r_flush_valid_q    <= w_flush_valid_d;
            r_flush_rob_idx_q  <= w_flush_rob_idx_d;
            r_stat_resolved_q  <= w_stat_resolved_d;
            r_stat_mispred_q   <= w_stat_mispred_d;
        end
    end

    assign bus.redirect_valid = r_redirect_valid_q;
    assign bus.redirect_pc    = r_redirect_pc_q;
    assign bus.flush_valid    = r_flush_valid_q;
    assign bus.flush_rob_idx  = r_flush_rob_idx_q;
    assign bus.stat_resolved  = r_stat_resolved_q;
    assign bus.stat_mispred   = r_stat_mispred_q;

endmodule
`default_nettype wire

// File: tb/tb_superh16_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_superh16_branch_redirect_ctrl
// Description : Directed self-checking bench for the branch redirect controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_superh16_branch_redirect_ctrl;
    localparam int c_NUM_BR = 2;
    localparam int c_VA     = 64;
    localparam int c_RB     = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    superh16_branch_redirect_ctrl_if #(
        .NUM_BR(c_NUM_BR), .VADDR_WIDTH(c_VA), .ROB_IDX_BITS(c_RB)
    ) bus ();

    superh16_branch_redirect_ctrl #(
        .NUM_BR(c_NUM_BR), .VADDR_WIDTH(c_VA), .ROB_IDX_BITS(c_RB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle so outputs reflect the inputs just sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.br_resolved     = '0;
        bus.br_mispredicted = '0;
        bus.br_target       = '0;
        bus.br_rob_idx      = '0;
        bus.exc_flush       = 1'b0;
    endtask

    task automatic lane(input int i, input logic res, input logic mis,
                        input logic [7:0] idx, input logic [63:0] tgt);
        bus.br_resolved[i]          = res;
        bus.br_mispredicted[i]      = mis;
        bus.br_rob_idx[i*c_RB +: c_RB] = idx;
        bus.br_target[i*c_VA +: c_VA]  = tgt;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        bus.rob_head       = '0;
        bus.redirect_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_rv",    64'(bus.redirect_valid), 64'd0);
        chk("rst_pc",    bus.redirect_pc,         64'd0);
        chk("rst_fv",    64'(bus.flush_valid),    64'd0);
        chk("rst_fidx",  64'(bus.flush_rob_idx),  64'd0);
        chk("rst_sres",  64'(bus.stat_resolved),  64'd0);
        chk("rst_smis",  64'(bus.stat_mispred),   64'd0);
        #1 rst = 1'b0;

        // Resolved-but-correct and unqualified mispredict flags are not candidates.
        lane(0, 1'b0, 1'b1, 8'd4, 64'hAAAA);
        lane(1, 1'b1, 1'b0, 8'd6, 64'hBBBB);
        tick();
        chk("nocand_fv",   64'(bus.flush_valid),    64'd0);
        chk("nocand_rv",   64'(bus.redirect_valid), 64'd0);
        chk("nocand_sres", 64'(bus.stat_resolved),  64'd1);
        idle_inputs();

        // Basic single-lane mispredict with immediate acceptance.
        bus.redirect_ready = 1'b1;
        lane(0, 1'b1, 1'b1, 8'd5, 64'h1000);
        tick();
        chk("t1_fv",   64'(bus.flush_valid),    64'd1);
        chk("t1_fidx", 64'(bus.flush_rob_idx),  64'd5);
        chk("t1_rv",   64'(bus.redirect_valid), 64'd1);
        chk("t1_pc",   bus.redirect_pc,         64'h1000);
        chk("t1_sres", 64'(bus.stat_resolved),  64'd2);
        idle_inputs();
        tick();
        chk("t1_rv_done", 64'(bus.redirect_valid), 64'd0);
        chk("t1_fv_done", 64'(bus.flush_valid),    64'd0);
        chk("t1_smis",    64'(bus.stat_mispred),   64'd1);

        // Wrap-around ages: head 248, lane1 idx 250 (age 2) beats lane0 idx 3 (age 11).
        bus.redirect_ready = 1'b0;
        bus.rob_head = 8'd248;
        lane(0, 1'b1, 1'b1, 8'd3,   64'h2000);
        lane(1, 1'b1, 1'b1, 8'd250, 64'h3000);
        tick();
        chk("t2_fidx", 64'(bus.flush_rob_idx), 64'd250);
        chk("t2_pc",   bus.redirect_pc,        64'h3000);
        chk("t2_sres", 64'(bus.stat_resolved), 64'd4);
        chk("t2_smis", 64'(bus.stat_mispred),  64'd2);
        idle_inputs();
        bus.redirect_ready = 1'b1;
        tick();
        chk("t2_rv_done", 64'(bus.redirect_valid), 64'd0);

        // Older replacement after fetch stalls for 4 cycles.
        bus.redirect_ready = 1'b0;
        bus.rob_head = 8'd0;
        lane(0, 1'b1, 1'b1, 8'd7, 64'h4000);
        tick();
        chk("t3_fidx_a", 64'(bus.flush_rob_idx), 64'd7);
        chk("t3_smis_a", 64'(bus.stat_mispred),  64'd3);
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_hold_rv", 64'(bus.redirect_valid), 64'd1);
            chk("t3_hold_fv", 64'(bus.flush_valid),    64'd0);
            chk("t3_hold_pc", bus.redirect_pc,         64'h4000);
        end
        lane(1, 1'b1, 1'b1, 8'd2, 64'h5000);
        tick();
        chk("t3_fv_b",   64'(bus.flush_valid),   64'd1);
        chk("t3_fidx_b", 64'(bus.flush_rob_idx), 64'd2);
        chk("t3_pc_b",   bus.redirect_pc,        64'h5000);
        chk("t3_smis_b", 64'(bus.stat_mispred),  64'd4);
        chk("t3_sres_b", 64'(bus.stat_resolved), 64'd6);
        idle_inputs();

        // Younger mispredict while redirecting is wrong-path.
        lane(0, 1'b1, 1'b1, 8'd9, 64'h6000);
        tick();
        chk("t4_fv",   64'(bus.flush_valid),   64'd0);
        chk("t4_pc",   bus.redirect_pc,        64'h5000);
        chk("t4_fidx", 64'(bus.flush_rob_idx), 64'd2);
        chk("t4_sres", 64'(bus.stat_resolved), 64'd7);
        chk("t4_smis", 64'(bus.stat_mispred),  64'd4);
        idle_inputs();

        // Exception flush dominates an otherwise-accepted older pick.
        bus.exc_flush = 1'b1;
        lane(0, 1'b1, 1'b1, 8'd1, 64'h7000);
        tick();
        chk("t5_rv",   64'(bus.redirect_valid), 64'd0);
        chk("t5_fv",   64'(bus.flush_valid),    64'd0);
        chk("t5_smis", 64'(bus.stat_mispred),   64'd4);
        chk("t5_sres", 64'(bus.stat_resolved),  64'd8);
        idle_inputs();
        tick();
        chk("t5_idle_rv", 64'(bus.redirect_valid), 64'd0);

        // Equal age on both lanes: lane 0 wins.
        lane(0, 1'b1, 1'b1, 8'd10, 64'h8000);
        lane(1, 1'b1, 1'b1, 8'd10, 64'h9000);
        tick();
        chk("tie_pc",   bus.redirect_pc,        64'h8000);
        chk("tie_smis", 64'(bus.stat_mispred),  64'd5);
        idle_inputs();

        // Reset mid-redirect returns everything to reset values.
        rst = 1'b1;
        tick();
        chk("mrst_rv",   64'(bus.redirect_valid), 64'd0);
        chk("mrst_pc",   bus.redirect_pc,         64'd0);
        chk("mrst_smis", 64'(bus.stat_mispred),   64'd0);
        chk("mrst_sres", 64'(bus.stat_resolved),  64'd0);
        rst = 1'b0;

        // Saturation: preload near max, then two resolutions per cycle.
        force dut.r_stat_resolved_q = 32'hFFFF_FFFC;
        #1;
        release dut.r_stat_resolved_q;
        lane(0, 1'b1, 1'b0, 8'd20, 64'h0);
        lane(1, 1'b1, 1'b0, 8'd21, 64'h0);
        tick();
        chk("sat_1", 64'(bus.stat_resolved), 64'hFFFF_FFFE);
        tick();
        chk("sat_2", 64'(bus.stat_resolved), 64'hFFFF_FFFF);
        tick();
        chk("sat_3", 64'(bus.stat_resolved), 64'hFFFF_FFFF);
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/superh16_branch_redirect_ctrl.md
Name: superh16_branch_redirect_ctrl

Overview:
- Consumes per-lane branch resolutions from the branch execution units.
- Selects the oldest mispredicted branch by ROB age and broadcasts a one-cycle flush of all younger ROB entries.
- Holds a redirect request to fetch until fetch accepts it, and keeps saturating resolve/mispredict statistics.
- Sits between the execute stage and the frontend/ROB recovery logic.

Parameters:
- NUM_BR, 2: number of branch resolution lanes.
- VADDR_WIDTH, 64: virtual address width.
- ROB_IDX_BITS, 8: ROB index width; the ROB has 2^ROB_IDX_BITS entries.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- br_resolved  in  NUM_BR  per-lane resolution valid.
- br_mispredicted  in  NUM_BR  per-lane mispredict flag; qualified by br_resolved.
- br_target  in  NUM_BR*VADDR_WIDTH  per-lane correct next PC; lane i at [i*VADDR_WIDTH +: VADDR_WIDTH].
- br_rob_idx  in  NUM_BR*ROB_IDX_BITS  per-lane ROB index of the branch.
- rob_head  in  ROB_IDX_BITS  index of the oldest ROB entry; used as the age reference.
- exc_flush  in  1  exception/commit flush; cancels all pending branch recovery.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_valid  out  1  redirect request pending.
- redirect_pc  out  VADDR_WIDTH  fetch restart PC.
- flush_valid  out  1  one-cycle pulse: kill ROB entries strictly younger than flush_rob_idx.
- flush_rob_idx  out  ROB_IDX_BITS  index of the mispredicting branch.
- stat_resolved  out  32  count of resolved branches, saturating.
- stat_mispred  out  32  count of accepted mispredicts, saturating.

Behaviour:
- Age rule:
  - age(x) = (x - rob_head) mod 2^ROB_IDX_BITS; a smaller value is older.
  - Wrap-around is handled by the modular subtraction only.
- Candidate selection (combinational, each cycle):
  - Candidates are lanes with br_resolved & br_mispredicted.
  - The pick is the candidate with the smallest age.
  - On equal age (illegal in practice), the lower lane wins.
- FSM states are IDLE and REDIRECT. Reset state is IDLE.
- Reset values: redirect_valid=0, redirect_pc=0, flush_valid=0, flush_rob_idx=0, both stats=0.
- IDLE:
  - If a pick exists: latch pick target/rob_idx, pulse flush_valid=1 in the next cycle with flush_rob_idx=pick rob_idx, then go to REDIRECT.
  - redirect_valid rises in the same cycle as the flush pulse. Latency from input to outputs is 1 cycle.
- REDIRECT:
  - redirect_valid=1; redirect_pc and flush_rob_idx are held stable.
  - Redirect completes on redirect_valid & redirect_ready, then go to IDLE.
  - If a pick is strictly older than the latched branch: replace redirect_pc/flush_rob_idx, re-pulse flush_valid next cycle, and stay in REDIRECT even if the handshake also fires that cycle. Fetch sees the new PC as a new request.
  - Picks that are younger or equal are ignored; they are wrong-path.
- Return to IDLE with a simultaneous new pick: the new pick is accepted in that same cycle. Resolutions are not filtered against the just-completed branch. Upstream must not present wrong-path resolutions after the flush pulse.
- exc_flush has highest priority in any state:
  - Next cycle: FSM=IDLE, redirect_valid=0, flush_valid=0.
  - Picks presented in the same cycle are discarded and are not counted in stat_mispred.
- flush_valid is never asserted for two consecutive cycles for the same rob_idx.
- Stats:
  - stat_resolved += popcount(br_resolved) each cycle, including wrong-path lanes.
  - stat_mispred += 1 per accepted pick (the IDLE accept or an older replacement).
  - Both saturate at 0xFFFF_FFFF.
- rst asserted mid-redirect: outputs return to their reset values next cycle; no handshake completion is implied.

Test Plan:
- Lane 0 resolved and mispredicted, rob_idx=5, target=0x1000, rob_head=0, redirect_ready=1 -> next cycle flush_valid=1, flush_rob_idx=5, redirect_valid=1, redirect_pc=0x1000; the following cycle redirect_valid=0, stat_mispred=1.
- Both lanes mispredict, lane0 rob_idx=3, lane1 rob_idx=250, rob_head=248 -> lane1 is older (age 2 vs 11); flush_rob_idx=250, redirect_pc=lane1 target.
- redirect_ready=0 for 4 cycles, then a mispredict at rob_idx=2 arrives against latched rob_idx=7 with rob_head=0 -> second flush pulse with flush_rob_idx=2; redirect_pc switches to the new target; stat_mispred=2.
- While latched rob_idx=2, a mispredict at rob_idx=9 arrives -> no flush pulse, redirect_pc unchanged, stat_resolved increments by 1.
- exc_flush asserted in the same cycle as a lane-0 mispredict while in REDIRECT -> next cycle redirect_valid=0, flush_valid=0, stat_mispred unchanged.
- Preload stat_resolved near 0xFFFF_FFFF (or force), then drive 2 resolutions per cycle -> stat_resolved holds at 0xFFFF_FFFF and never wraps.
